// File: rtl/debounce_pkg.sv
// Shared helpers for the debounce family: prescaler top-count derivation and a
// parameter guard that stops elaboration when a block is configured out of range.
`ifndef DEBOUNCE_PKG_SV
`define DEBOUNCE_PKG_SV

`define DEBOUNCE_RANGE_CHECK(label, cond) \
    if (!(cond)) begin : label \
        $fatal(1, "debounce: parameter out of range"); \
    end

package debounce_pkg;

    function automatic longint calc_top(input int simulate, input longint sim_cnt,
                                        input longint clk_hz, input longint deb_hz);
        if (simulate != 0) return sim_cnt;
        if (deb_hz <= 0) return -1;
        return (clk_hz / deb_hz) - 1;
    endfunction

    function automatic bit top_fits(input longint top, input int width);
        return (top >= 0) && ((width >= 63) || ((top >> width) == 0));
    endfunction

endpackage

`endif

// File: rtl/debounce_prescaler.sv
// Free-running sample prescaler: counts 0..TOP while enabled and emits a
// registered one-cycle sample_tick in the cycle after the count reaches TOP.
module debounce_prescaler
    import debounce_pkg::*;
#(
    parameter int     CNTR_WIDTH = 32,
    parameter longint TOP        = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic sample_tick
);

    `DEBOUNCE_RANGE_CHECK(g_chk_width, (CNTR_WIDTH >= 1) && (CNTR_WIDTH <= 64))
    `DEBOUNCE_RANGE_CHECK(g_chk_top, top_fits(TOP, CNTR_WIDTH))

    localparam logic [CNTR_WIDTH-1:0] TOP_CNT = CNTR_WIDTH'(TOP);

    logic [CNTR_WIDTH-1:0] count;
    logic                  at_top;

    assign at_top = (count == TOP_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= enable && at_top;
            if (enable) begin
                count <= at_top ? '0 : count + CNTR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/multi_debounce.sv
// N-channel debouncer: per-channel synchroniser, shift register sampled on a
// shared prescaled tick, registered level output and one-cycle rise/fall pulses.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int DEBOUNCE_FREQUENCY_HZ  = 250,
    parameter int CNTR_WIDTH             = 32,
    parameter int NUM_CHANNELS           = 8,
    parameter int SAMPLE_DEPTH           = 4,
    parameter int SYNC_STAGES            = 2,
    parameter int RESET_LEVEL            = 0,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] signal_in,
    output logic [NUM_CHANNELS-1:0] signal_out,
    output logic [NUM_CHANNELS-1:0] rise_pulse,
    output logic [NUM_CHANNELS-1:0] fall_pulse,
    output logic                    sample_tick
);

    `DEBOUNCE_RANGE_CHECK(g_chk_channels, NUM_CHANNELS >= 1)
    `DEBOUNCE_RANGE_CHECK(g_chk_depth, SAMPLE_DEPTH >= 2)
    `DEBOUNCE_RANGE_CHECK(g_chk_sync, SYNC_STAGES >= 2)
    `DEBOUNCE_RANGE_CHECK(g_chk_level, (RESET_LEVEL == 0) || (RESET_LEVEL == 1))
    `DEBOUNCE_RANGE_CHECK(g_chk_simcnt, SIMULATE_FREQUENCY_CNT >= 0)

    localparam longint TOP     = calc_top(SIMULATE, SIMULATE_FREQUENCY_CNT,
                                          CLK_FREQUENCY_HZ, DEBOUNCE_FREQUENCY_HZ);
    localparam logic   RST_BIT = (RESET_LEVEL != 0);

    debounce_prescaler #(
        .CNTR_WIDTH (CNTR_WIDTH),
        .TOP        (TOP)
    ) u_prescaler (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .sample_tick (sample_tick)
    );

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0]  sync_p0;
        logic [SAMPLE_DEPTH-1:0] sr_p1;
        logic                    out_p2;
        logic                    rise_p2;
        logic                    fall_p2;
        logic                    sync_q;
        logic                    all_ones;
        logic                    all_zeros;

        assign sync_q    = sync_p0[SYNC_STAGES-1];
        assign all_ones  = &sr_p1;
        assign all_zeros = ~|sr_p1;

        // sync_p0 -> sr_p1 on tick -> out_p2 / pulses one cycle after sr turns uniform
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_p0 <= {SYNC_STAGES{RST_BIT}};
                sr_p1   <= {SAMPLE_DEPTH{RST_BIT}};
                out_p2  <= RST_BIT;
                rise_p2 <= 1'b0;
                fall_p2 <= 1'b0;
            end else begin
                sync_p0 <= {sync_p0[SYNC_STAGES-2:0], signal_in[i]};
                if (sample_tick) begin
                    sr_p1 <= {sr_p1[SAMPLE_DEPTH-2:0], sync_q};
                end
                rise_p2 <= all_ones & ~out_p2;
                fall_p2 <= all_zeros & out_p2;
                if (all_ones) begin
                    out_p2 <= 1'b1;
                end else if (all_zeros) begin
                    out_p2 <= 1'b0;
                end
            end
        end

        assign signal_out[i] = out_p2;
        assign rise_pulse[i] = rise_p2;
        assign fall_pulse[i] = fall_p2;
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a sample-history reference model.
`timescale 1ns/1ps
module tb_multi_debounce;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int TOPC  = 5;
    localparam int PER   = TOPC + 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           enable = 1'b0;
    logic [NCH-1:0] signal_in = '0;
    logic [NCH-1:0] signal_out;
    logic [NCH-1:0] rise_pulse;
    logic [NCH-1:0] fall_pulse;
    logic           sample_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_debounce #(
        .CLK_FREQUENCY_HZ       (100000000),
        .DEBOUNCE_FREQUENCY_HZ  (250),
        .CNTR_WIDTH             (32),
        .NUM_CHANNELS           (NCH),
        .SAMPLE_DEPTH           (DEPTH),
        .SYNC_STAGES            (SYNC),
        .RESET_LEVEL            (0),
        .SIMULATE               (1),
        .SIMULATE_FREQUENCY_CNT (TOPC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .signal_in   (signal_in),
        .signal_out  (signal_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .sample_tick (sample_tick)
    );

    // Reference model: raw-input history gives the synchronised value, a list of
    // the last DEPTH samples per channel decides the level, enabled cycles give ticks.
    bit             model_ready = 1'b0;
    int             en_cnt;
    bit             m_tick;
    bit [NCH-1:0]   m_out, m_rise, m_fall;
    bit [NCH-1:0]   in_q[$];
    bit             smp[NCH][$];

    function automatic void model_reset();
        en_cnt = 0;
        m_tick = 1'b0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        in_q.delete();
        repeat (SYNC) in_q.push_back('0);
        for (int c = 0; c < NCH; c++) begin
            smp[c].delete();
            repeat (DEPTH) smp[c].push_back(1'b0);
        end
        model_ready = 1'b1;
    endfunction

    function automatic bit all_same(int c);
        for (int k = 1; k < DEPTH; k++) begin
            if (smp[c][k] != smp[c][0]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            model_reset();
        end else if (model_ready) begin
            bit [NCH-1:0] sq;
            bit [NCH-1:0] nout;
            sq = in_q.pop_front();
            in_q.push_back(signal_in);
            for (int c = 0; c < NCH; c++) begin
                nout[c] = all_same(c) ? smp[c][0] : m_out[c];
            end
            if (m_tick) begin
                for (int c = 0; c < NCH; c++) begin
                    smp[c].push_back(sq[c]);
                    void'(smp[c].pop_front());
                end
            end
            m_rise = nout & ~m_out;
            m_fall = m_out & ~nout;
            m_out  = nout;
            m_tick = enable && ((en_cnt % PER) == PER - 1);
            if (enable) en_cnt++;
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            n_checks++;
            if ({signal_out, rise_pulse, fall_pulse, sample_tick} !==
                {m_out, m_rise, m_fall, m_tick}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got out=%b rise=%b fall=%b tick=%b, expected out=%b rise=%b fall=%b tick=%b",
                         $time, signal_out, rise_pulse, fall_pulse, sample_tick,
                         m_out, m_rise, m_fall, m_tick);
            end
            n_checks++;
            if ((rise_pulse & fall_pulse) !== '0) begin
                n_fail++;
                $display("FAIL rise_fall_exclusive t=%0t: got rise=%b fall=%b, expected no overlap",
                         $time, rise_pulse, fall_pulse);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  ticks;
        bit  seen;
        bit  held;

        // 1. reset with inputs high, then tick timing
        #2;
        reset_n   = 1'b0;
        signal_in = 4'hF;
        #1;
        check("reset_out_immediate", signal_out, 0);
        repeat (3) nc();
        check("reset_out", signal_out, 0);
        check("reset_pulses", {rise_pulse, fall_pulse}, 0);
        check("reset_tick", sample_tick, 0);
        signal_in = 4'h0;
        enable    = 1'b1;
        reset_n   = 1'b1;
        cnt = 0;
        while (!sample_tick && cnt < 50) begin nc(); cnt++; end
        check("first_tick_cycle", cnt, 6);
        cnt = 0;
        do begin nc(); cnt++; end while (!sample_tick && cnt < 50);
        check("tick_period", cnt, 6);

        // 2. clean rise on ch0
        repeat (3) nc();
        signal_in[0] = 1'b1;
        cnt = 0;
        while (!signal_out[0] && cnt < 60) begin nc(); cnt++; end
        check("rise_latency_in_range", (cnt >= 22 && cnt <= 28), 1);
        check("rise_cycle_outputs", {signal_out, rise_pulse, fall_pulse}, {4'b0001, 4'b0001, 4'b0000});
        nc();
        check("rise_pulse_one_cycle", {signal_out, rise_pulse, fall_pulse}, {4'b0001, 4'b0000, 4'b0000});

        // 3. glitch on ch1
        signal_in[1] = 1'b1;
        seen = 1'b0;
        repeat (8) begin nc(); seen |= signal_out[1] | rise_pulse[1] | fall_pulse[1]; end
        signal_in[1] = 1'b0;
        repeat (40) begin nc(); seen |= signal_out[1] | rise_pulse[1] | fall_pulse[1]; end
        check("glitch_rejected_ch1", seen, 0);

        // 4. simultaneous rise on ch2 and fall on ch3
        signal_in[3] = 1'b1;
        repeat (40) nc();
        check("ch3_debounced_high", signal_out[3], 1);
        signal_in[2] = 1'b1;
        signal_in[3] = 1'b0;
        cnt = 0;
        while (!rise_pulse[2] && cnt < 60) begin nc(); cnt++; end
        check("ch2_rise_seen", rise_pulse[2], 1);
        check("ch3_fall_same_cycle", fall_pulse[3], 1);
        check("simul_outputs", signal_out, 4'b0101);

        // 5. enable freeze during a ch0 fall
        cnt = 0;
        while (!sample_tick && cnt < 20) begin nc(); cnt++; end
        signal_in[0] = 1'b0;
        ticks = 0;
        cnt = 0;
        while (ticks < 2 && cnt < 30) begin nc(); cnt++; if (sample_tick) ticks++; end
        enable = 1'b0;
        seen = 1'b0;
        held = 1'b1;
        repeat (30) begin
            nc();
            if (sample_tick) seen = 1'b1;
            if (!signal_out[0] || fall_pulse[0]) held = 1'b0;
        end
        check("freeze_no_tick", seen, 0);
        check("freeze_output_held", held, 1);
        enable = 1'b1;
        ticks = 0;
        cnt = 0;
        while (!fall_pulse[0] && cnt < 40) begin nc(); cnt++; if (sample_tick) ticks++; end
        check("resume_fall_seen", fall_pulse[0], 1);
        check("resume_ticks_to_finish", ticks, 2);

        // 6. reset while all outputs high and a pulse is active
        signal_in = 4'hF;
        cnt = 0;
        while (!(signal_out == 4'hF && rise_pulse != 0) && cnt < 60) begin nc(); cnt++; end
        check("all_high_with_pulse", (signal_out == 4'hF && rise_pulse != 0), 1);
        reset_n = 1'b0;
        #1;
        check("midreset_out", signal_out, 0);
        check("midreset_pulses", {rise_pulse, fall_pulse}, 0);
        repeat (2) nc();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin nc(); seen |= (|rise_pulse) | (|fall_pulse); end
        check("no_pulse_after_reset", seen, 0);

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            nc();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 24) == 0) signal_in[c] = ~signal_in[c];
            end
            if (enable) begin
                if ($urandom_range(0, 79) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) enable = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                repeat (2) nc();
                reset_n = 1'b1;
            end
        end
        nc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
